seq_timer_sched: RTL

//  Shares one sequential one-shot timer among NREQ requesters. Each requester strobes a

---
 rtl/seq_timer_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 38 +++
 rtl/seq_timer_sched.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/seq_timer_pkg.sv
// Shared definitions for the sequential timer scheduler.
// Holds the FSM state encoding and default sizing parameters.
package seq_timer_pkg;

    localparam int NREQ_DEF = 4;
    localparam int DW_DEF   = 12;
    localparam int IW_DEF   = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first pending index at or after rr_ptr.
// Ports: pending (NREQ) and rr_ptr (IW) in; gnt_vld and gnt_idx (IW) out.
// Purely combinational.
module rr_arbiter
    import seq_timer_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = IW_DEF
) (
    input  logic [NREQ-1:0] pending,
    input  logic [IW-1:0]   rr_ptr,
    output logic            gnt_vld,
    output logic [IW-1:0]   gnt_idx
);

    logic [IW:0]   sum;
    logic [IW-1:0] k;

    // Scan from rr_ptr upward with wrap; first hit wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        k       = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            k = sum[IW-1:0];
            if (!gnt_vld && pending[k]) begin
                gnt_vld = 1'b1;
                gnt_idx = k;
            end
        end
    end

endmodule

// File: rtl/seq_timer_sched.sv
// Shares one one-shot timer among NREQ requesters with round-robin service.
// Ports: clk, reset (sync, high), enable, req_strb, dur (packed counts) in;
// done, busy, gnt_idx, cntr out. Optional macro TIMER_ABORT_EN adds
// abort_strb in and aborted out.
module seq_timer_sched
    import seq_timer_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF,
    parameter int IW   = IW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [NREQ-1:0]  req_strb,
    input  logic [NREQ*DW-1:0] dur,
`ifdef TIMER_ABORT_EN
    input  logic             abort_strb,
    output logic [NREQ-1:0]  aborted,
`endif
    output logic [NREQ-1:0]  done,
    output logic             busy,
    output logic [IW-1:0]    gnt_idx,
    output logic [DW-1:0]    cntr
);

    state_e          state_q, state_d;
    logic [NREQ-1:0] pending_q, pending_d;
    logic [NREQ-1:0] pend_clr;
    logic [DW-1:0]   dur_q [NREQ];
    logic [DW-1:0]   dur_d [NREQ];
    logic [DW-1:0]   dur_run_q, dur_run_d;
    logic [DW-1:0]   cntr_q, cntr_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [IW-1:0]   rr_nxt;
    logic [NREQ-1:0] done_q, done_d;
    logic            arb_vld;
    logic [IW-1:0]   arb_idx;
`ifdef TIMER_ABORT_EN
    logic [NREQ-1:0] aborted_q, aborted_d;
`endif

    rr_arbiter #(
        .NREQ(NREQ),
        .IW  (IW)
    ) u_arb (
        .pending(pending_q),
        .rr_ptr (rr_q),
        .gnt_vld(arb_vld),
        .gnt_idx(arb_idx)
    );

    assign rr_nxt = (gnt_q == IW'(NREQ-1)) ? '0 : gnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cntr_d    = cntr_q;
        gnt_d     = gnt_q;
        rr_d      = rr_q;
        dur_run_d = dur_run_q;
        done_d    = '0;
        pend_clr  = '0;
`ifdef TIMER_ABORT_EN
        aborted_d = '0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (enable && arb_vld) begin
                    gnt_d          = arb_idx;
                    dur_run_d      = dur_q[arb_idx];
                    pend_clr[arb_idx] = 1'b1;
                    cntr_d         = '0;
                    state_d        = ST_RUN;
                end
            end
            ST_RUN: begin
                if (enable) begin
`ifdef TIMER_ABORT_EN
                    if (abort_strb) begin
                        aborted_d[gnt_q] = 1'b1;
                        rr_d    = rr_nxt;
                        state_d = ST_IDLE;
                    end else
`endif
                    if (cntr_q == dur_run_q) begin
                        done_d[gnt_q] = 1'b1;
                        rr_d    = rr_nxt;
                        state_d = ST_IDLE;
                    end else begin
                        cntr_d = cntr_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // A new strobe wins over the grant clear, so an owner can re-queue.
    always_comb begin
        pending_d = (pending_q & ~pend_clr) | req_strb;
        dur_d     = dur_q;
        for (int i = 0; i < NREQ; i++) begin
            if (req_strb[i]) begin
                dur_d[i] = dur[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            dur_q     <= '{default: '0};
            dur_run_q <= '0;
            cntr_q    <= '0;
            gnt_q     <= '0;
            rr_q      <= '0;
            done_q    <= '0;
`ifdef TIMER_ABORT_EN
            aborted_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            dur_q     <= dur_d;
            dur_run_q <= dur_run_d;
            cntr_q    <= cntr_d;
            gnt_q     <= gnt_d;
            rr_q      <= rr_d;
            done_q    <= done_d;
`ifdef TIMER_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    assign done    = done_q;
    assign busy    = (state_q == ST_RUN);
    assign gnt_idx = gnt_q;
    assign cntr    = cntr_q;
`ifdef TIMER_ABORT_EN
    assign aborted = aborted_q;
`endif

endmodule
